// File: rtl/red_sched.sv
// Round-robin front end for a shared polynomial reduction stage: it grants one of
// two requesters, holds its operands on the stage, waits out the latency and returns the result.
module red_sched #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [9*W-1:0] req0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [9*W-1:0] req1_data,
  output logic [9*W-1:0] stg_s,
  input  logic [5*W-1:0] stg_c,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [5*W-1:0] rsp_data,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t         state_reg;
  logic [3:0]     cnt_reg;
  logic           last_grant_reg;
  logic [9*W-1:0] op_reg;
  logic           gnt0, gnt1;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant_reg);
    gnt1 = req1_valid && (!req0_valid || !last_grant_reg);
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  assign req0_ready = reset && (state_reg == IDLE) && gnt0;
  assign req1_ready = reset && (state_reg == IDLE) && gnt1;
  assign busy       = (state_reg != IDLE);
  assign stg_s      = op_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      op_reg         <= '0;
      rsp_data       <= '0;
      rsp_id         <= 1'b0;
      rsp_valid      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_reg         <= gnt1 ? req1_data : req0_data;
            rsp_id         <= gnt1;
            last_grant_reg <= gnt1;
            cnt_reg        <= LAT_CNT;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            rsp_data  <= stg_c;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_sched.sv
// Directed bench for red_sched: a transaction-level model checks the LAT=1 instance
// every cycle; a LAT=3 instance with a hand-driven stage result checks capture timing.
module tb_red_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic           a_v0, a_v1, a_r0, a_r1, a_rv, a_rr, a_rid, a_busy;
  logic [9*W-1:0] a_d0, a_d1, a_stg_s;
  logic [5*W-1:0] a_stg_c, a_rd;
  logic           b_v0, b_v1, b_r0, b_r1, b_rv, b_rr, b_rid, b_busy;
  logic [9*W-1:0] b_d0, b_d1, b_stg_s;
  logic [5*W-1:0] b_stg_c, b_rd;

  red_sched #(.W(W), .LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_v0), .req0_ready(a_r0), .req0_data(a_d0),
    .req1_valid(a_v1), .req1_ready(a_r1), .req1_data(a_d1),
    .stg_s(a_stg_s), .stg_c(a_stg_c),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_rid), .rsp_data(a_rd),
    .busy(a_busy)
  );

  red_sched #(.W(W), .LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_ready(b_r0), .req0_data(b_d0),
    .req1_valid(b_v1), .req1_ready(b_r1), .req1_data(b_d1),
    .stg_s(b_stg_s), .stg_c(b_stg_c),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_rid), .rsp_data(b_rd),
    .busy(b_busy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] ops(input logic [7:0] b);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction

  function automatic logic [39:0] red_f(input logic [71:0] s);
    logic [7:0] v [9];
    logic [7:0] c0, c1, c2, c3, c4;
    for (int i = 0; i < 9; i++) v[i] = s[i*8 +: 8];
    c0 = v[0] - v[5] - v[6];
    c1 = v[1] - v[6];
    c2 = v[2] - v[7] - v[5] - v[8];
    c3 = v[3] - v[8] - v[6];
    c4 = v[4] - v[7];
    return {c4, c3, c2, c1, c0};
  endfunction

  // One-edge reduction stage feeding the LAT=1 instance.
  always @(posedge clk) a_stg_c <= red_f(a_stg_s);

  // Transaction model: an accepted op produces its response after edge accept+2.
  logic        m_busy, m_resp, m_last, m_id;
  logic [71:0] m_op;
  logic [39:0] m_data;
  int          ecount = 0;
  int          m_cap  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_id = 1'b0;
      m_op = '0; m_data = '0;
    end else begin
      ecount++;
      if (!m_busy) begin
        if (a_v0 || a_v1) begin
          m_id   = a_v1 && (!a_v0 || !m_last);
          m_last = m_id;
          m_op   = m_id ? a_d1 : a_d0;
          m_busy = 1'b1;
          m_cap  = ecount + 2;
        end
      end else if (!m_resp) begin
        if (ecount == m_cap) begin
          m_resp = 1'b1;
          m_data = red_f(m_op);
        end
      end else if (a_rr) begin
        m_resp = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("cyc_ready0", a_r0, !m_busy && a_v0 && (!a_v1 || m_last));
      chk("cyc_ready1", a_r1, !m_busy && a_v1 && (!a_v0 || !m_last));
      chk("cyc_busy", a_busy, m_busy);
      chk("cyc_rsp_valid", a_rv, m_resp);
      chk("cyc_rsp_id", a_rid, m_id);
      chk("cyc_rsp_data", a_rd, m_data);
      chk("cyc_stg_s", a_stg_s, m_op);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic got [4];
  int   n;

  initial begin
    a_v0 = 1'b1; a_v1 = 1'b0; a_d0 = ops(8'h50); a_d1 = '0; a_rr = 1'b1;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0; b_rr = 1'b1; b_stg_c = '0;
    reset = 1'b0;
    tick(); tick();
    chk("rst_ready0", a_r0, 1'b0);
    chk("rst_ready1", a_r1, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rsp_valid", a_rv, 1'b0);
    chk("rst_stg_s", a_stg_s, 72'h0);
    chk("rst_rsp_id", a_rid, 1'b0);
    chk("rst_rsp_data", a_rd, 40'h0);
    $display("reset state checked");

    // Single op, s0..s8 = 1..9, accepted on the first edge after release
    a_d0 = ops(8'h01);
    reset = 1'b1;
    tick();
    chk("t1_busy", a_busy, 1'b1);
    chk("t1_stg_s", a_stg_s, 72'h090807060504030201);
    chk("t1_ready0_low", a_r0, 1'b0);
    a_v0 = 1'b0;
    tick();
    chk("t1_valid_k1", a_rv, 1'b0);
    tick();
    chk("t1_valid_k2", a_rv, 1'b1);
    chk("t1_rsp_id", a_rid, 1'b0);
    chk("t1_rsp_data", a_rd, 40'hFDF4ECFBF4);
    tick();
    chk("t1_done_valid", a_rv, 1'b0);
    chk("t1_done_busy", a_busy, 1'b0);
    $display("single op: rsp_id=0 rsp_data=%h", 40'hFDF4ECFBF4);

    // Reset asserted while in WAIT
    a_v0 = 1'b1; a_d0 = ops(8'h20);
    tick();
    a_v0 = 1'b0; a_v1 = 1'b1; a_d1 = ops(8'h30);
    #1 reset = 1'b0;
    #1;
    chk("rw_rsp_valid", a_rv, 1'b0);
    chk("rw_busy", a_busy, 1'b0);
    chk("rw_stg_s", a_stg_s, 72'h0);
    chk("rw_ready0", a_r0, 1'b0);
    chk("rw_ready1", a_r1, 1'b0);
    #1 reset = 1'b1;
    tick();
    chk("rw_acc_busy", a_busy, 1'b1);
    chk("rw_acc_id", a_rid, 1'b1);
    chk("rw_acc_stg_s", a_stg_s, ops(8'h30));
    a_v1 = 1'b0;
    tick();
    chk("rw_no_stale", a_rv, 1'b0);
    tick();
    chk("rw_rsp_valid2", a_rv, 1'b1);
    chk("rw_rsp_data", a_rd, red_f(ops(8'h30)));
    tick();
    $display("reset in WAIT: op dropped, req1 accepted after release");

    // Tie fairness from reset
    reset = 1'b0;
    #1 reset = 1'b1;
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = ops(8'h40); a_d1 = ops(8'h60);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (a_rv) begin
        got[n] = a_rid;
        $display("tie response %0d: rsp_id=%0d", n, a_rid);
        n++;
      end
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    chk("tie_count", 80'(n), 80'd4);
    chk("tie_id0", got[0], 1'b0);
    chk("tie_id1", got[1], 1'b1);
    chk("tie_id2", got[2], 1'b0);
    chk("tie_id3", got[3], 1'b1);
    tick();

    // Backpressure in RESP
    a_rr = 1'b0; a_v0 = 1'b1; a_d0 = ops(8'h70);
    tick();
    a_v0 = 1'b0;
    tick(); tick();
    chk("bp_valid", a_rv, 1'b1);
    a_v0 = 1'b1; a_v1 = 1'b1; a_d1 = ops(8'h80);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", a_rv, 1'b1);
      chk("bp_hold_data", a_rd, red_f(ops(8'h70)));
      chk("bp_hold_id", a_rid, 1'b0);
      chk("bp_hold_busy", a_busy, 1'b1);
      chk("bp_hold_ready0", a_r0, 1'b0);
      chk("bp_hold_ready1", a_r1, 1'b0);
    end
    a_rr = 1'b1;
    tick();
    chk("bp_idle_busy", a_busy, 1'b0);
    chk("bp_idle_ready1", a_r1, 1'b1);
    chk("bp_idle_ready0", a_r0, 1'b0);
    tick();
    chk("bp_acc_busy", a_busy, 1'b1);
    chk("bp_acc_id", a_rid, 1'b1);
    chk("bp_acc_stg_s", a_stg_s, ops(8'h80));
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick(); tick(); tick();
    $display("backpressure: response held 5 cycles, req1 accepted after release");

    // Single-requester stream on req1
    a_v1 = 1'b1; a_d1 = ops(8'h90);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (a_rv) begin
        chk("st_id", a_rid, 1'b1);
        $display("stream response %0d: rsp_id=%0d", n, a_rid);
        n++;
      end
    end
    a_v1 = 1'b0;
    chk("st_count", 80'(n), 80'd3);
    tick(); tick();

    // LAT=3 capture timing on the second instance
    b_v0 = 1'b1; b_d0 = ops(8'hA0); b_rr = 1'b0; b_stg_c = 40'h1111111111;
    tick();
    b_v0 = 1'b0;
    chk("lb_busy", b_busy, 1'b1);
    chk("lb_stg_s", b_stg_s, ops(8'hA0));
    chk("lb_ready0", b_r0, 1'b0);
    chk("lb_ready1", b_r1, 1'b0);
    tick(); b_stg_c = 40'h2222222222;
    tick(); b_stg_c = 40'h3333333333;
    tick();
    chk("lb_valid_k3", b_rv, 1'b0);
    b_stg_c = 40'h0123456789;
    tick();
    chk("lb_valid_k4", b_rv, 1'b1);
    chk("lb_rsp_data", b_rd, 40'h0123456789);
    chk("lb_rsp_id", b_rid, 1'b0);
    b_stg_c = 40'hFFFFFFFFFF;
    tick();
    chk("lb_hold_data", b_rd, 40'h0123456789);
    b_rr = 1'b1;
    tick();
    chk("lb_done", b_rv, 1'b0);
    $display("LAT=3: captured %h at edge k+4", b_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
